// File: rtl/osd_pkg.sv
// Shared opcodes, command-parser states and the per-channel blend for the OSD overlay.
package osd_pkg;

    localparam logic [3:0] OSD_CMD_EN = 4'h4;
    localparam logic [2:0] OSD_CMD_WR = 3'b001;
    localparam int         SCALE_W    = 2;

    typedef enum logic [2:0] {
        CMD_IDLE,
        CMD_X,
        CMD_Y,
        CMD_SCALE,
        CMD_WRITE,
        CMD_IGNORE
    } cmd_state_e;

    // Lit pixels go full white; unlit pixels dim the background and optionally add a tint.
    function automatic logic [7:0] osd_blend(input logic [7:0] c, input logic on,
                                             input logic tint, input logic [1:0] shift);
        if (on) return 8'hFF;
        return (c >> shift) | (tint ? 8'h40 : 8'h00);
    endfunction

endpackage

// File: rtl/osd_cmd_if.sv
// Command/write port of the OSD overlay: frame select, word strobe and 16-bit data word.
interface osd_cmd_if;

    logic        io_osd;
    logic        io_strobe;
    logic [15:0] io_din;

    modport master (output io_osd, io_strobe, io_din);
    modport slave  (input  io_osd, io_strobe, io_din);

endinterface

// File: rtl/osd_bitmap_ram.sv
// Simple dual-port single-clock bitmap store; a read colliding with a write returns old data.
module osd_bitmap_ram #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_video,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [7:0]    wd,
    input  logic [AW-1:0] ra,
    output logic [7:0]    rd
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it would cost a full sweep and contents are don't-care after reset.
    always_ff @(posedge clk_video) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end

endmodule

// File: rtl/osd_overlay_ms.sv
// Inline OSD overlay: command parser, shadowed placement, geometry measurement and a 4-stage blend pipe.
module osd_overlay_ms
    import osd_pkg::*;
#(
    parameter int         OSD_W     = 256,
    parameter int         OSD_H     = 64,
    parameter logic [2:0] OSD_COLOR = 3'd4,
    parameter int         DIM_SHIFT = 1
) (
    input  logic        clk_video,
    input  logic        reset,
    osd_cmd_if.slave    cmd,
    input  logic [23:0] din,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [23:0] dout,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        osd_status
);

    localparam int DEPTH = OSD_W * OSD_H / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int XW    = $clog2(OSD_W);
    localparam int YW    = $clog2(OSD_H);
    localparam int NBLK  = OSD_H / 8;
    localparam logic [1:0] DSH = 2'(DIM_SHIFT);

    cmd_state_e         state_q, state_d;
    logic               strobe_q, stb_rise, is_cmd_word;
    logic               ld_en, ld_x, ld_y, ld_sc, ld_addr, wr_en;
    logic               en_q, pos_q;
    logic [11:0]        x_q, y_q;
    logic [SCALE_W-1:0] sc_q;
    logic [AW-1:0]      wr_addr, start_addr;

    assign stb_rise    = cmd.io_strobe & ~strobe_q & cmd.io_osd;
    // Command words are byte values; a word with a non-zero upper byte never opens a command.
    assign is_cmd_word = (cmd.io_din[15:8] == 8'h00);
    assign start_addr  = AW'((32'(cmd.io_din[4:0]) % NBLK) * OSD_W);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_video or posedge reset) begin
        if (reset) begin
            state_q  <= CMD_IDLE;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            strobe_q <= cmd.io_strobe;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ld_en   = 1'b0;
        ld_x    = 1'b0;
        ld_y    = 1'b0;
        ld_sc   = 1'b0;
        ld_addr = 1'b0;
        wr_en   = 1'b0;
        if (!cmd.io_osd) begin
            state_d = CMD_IDLE;
        end else if (stb_rise) begin
            case (state_q)
                CMD_IDLE: begin
                    if (is_cmd_word && cmd.io_din[7:4] == OSD_CMD_EN) begin
                        state_d = CMD_X;
                        ld_en   = 1'b1;
                    end else if (is_cmd_word && cmd.io_din[7:5] == OSD_CMD_WR) begin
                        state_d = CMD_WRITE;
                        ld_addr = 1'b1;
                    end else begin
                        state_d = CMD_IGNORE;
                    end
                end
                CMD_X:     begin ld_x  = 1'b1; state_d = CMD_Y;      end
                CMD_Y:     begin ld_y  = 1'b1; state_d = CMD_SCALE;  end
                CMD_SCALE: begin ld_sc = 1'b1; state_d = CMD_IGNORE; end
                CMD_WRITE: wr_en = 1'b1;
                default:   state_d = CMD_IGNORE;
            endcase
        end
    end

    always_ff @(posedge clk_video or posedge reset) begin
        if (reset) begin
            en_q    <= 1'b0;
            pos_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sc_q    <= '0;
            wr_addr <= '0;
        end else begin
            if (ld_en) begin
                en_q  <= cmd.io_din[0];
                pos_q <= cmd.io_din[1];
            end
            if (ld_x)  x_q  <= cmd.io_din[11:0];
            if (ld_y)  y_q  <= cmd.io_din[11:0];
            if (ld_sc) sc_q <= cmd.io_din[SCALE_W-1:0];
            if (ld_addr)    wr_addr <= start_addr;
            else if (wr_en) wr_addr <= (wr_addr == AW'(DEPTH - 1)) ? '0 : wr_addr + 1'b1;
        end
    end

    // Raster side: stage 1 registers, measurement, active (shadow) registers and repeat counters.
    logic [23:0]        din1, din2, dout3;
    logic               de1, hs1, vs1, de2, hs2, vs2, de3, hs3, vs3;
    logic               vs_rise, de_fall, inx, iny, win1, win2;
    logic [11:0]        px_cnt, ln_cnt, dsp_w, dsp_h, x0, y0;
    logic [12:0]        win_w, win_h;
    logic               seen_vs, meas_valid;
    logic               act_en, act_pos;
    logic [11:0]        act_x, act_y;
    logic [SCALE_W-1:0] act_sc, rx_q, ry_q;
    logic [XW-1:0]      sx_q;
    logic [YW-1:0]      sy_q;
    logic [AW-1:0]      rd_addr;
    logic [7:0]         rd_data;
    logic [2:0]         bit2;
    logic               pix_on;

    assign vs_rise = vs1 & ~vs2;
    assign de_fall = ~de1 & de2;
    assign win_w   = 13'(OSD_W * (int'(act_sc) + 1));
    assign win_h   = 13'(OSD_H * (int'(act_sc) + 1));

    always_comb begin
        x0 = act_x;
        y0 = act_y;
        if (!act_pos) begin
            x0 = ({1'b0, dsp_w} > win_w) ? 12'(({1'b0, dsp_w} - win_w) >> 1) : 12'd0;
            y0 = ({1'b0, dsp_h} > win_h) ? 12'(({1'b0, dsp_h} - win_h) >> 1) : 12'd0;
        end
    end

    assign inx     = ({1'b0, px_cnt} >= {1'b0, x0}) && ({1'b0, px_cnt} < {1'b0, x0} + win_w);
    assign iny     = ({1'b0, ln_cnt} >= {1'b0, y0}) && ({1'b0, ln_cnt} < {1'b0, y0} + win_h);
    assign win1    = de1 & inx & iny & act_en & meas_valid;
    assign rd_addr = AW'(32'(sy_q >> 3) * OSD_W + 32'(sx_q));

    always_ff @(posedge clk_video or posedge reset) begin
        if (reset) begin
            {din1, de1, hs1, vs1} <= '0;
            px_cnt     <= '0;
            ln_cnt     <= '0;
            dsp_w      <= '0;
            dsp_h      <= '0;
            seen_vs    <= 1'b0;
            meas_valid <= 1'b0;
            act_en     <= 1'b0;
            act_pos    <= 1'b0;
            act_x      <= '0;
            act_y      <= '0;
            act_sc     <= '0;
            sx_q       <= '0;
            rx_q       <= '0;
            sy_q       <= '0;
            ry_q       <= '0;
        end else begin
            {din1, de1, hs1, vs1} <= {din, de_in, hs_in, vs_in};
            px_cnt <= de1 ? px_cnt + 1'b1 : 12'd0;
            if (de_fall) dsp_w <= px_cnt;
            if (vs_rise) begin
                ln_cnt  <= '0;
                dsp_h   <= ln_cnt;
                seen_vs <= 1'b1;
                if (seen_vs) meas_valid <= 1'b1;
                act_en  <= en_q;
                act_pos <= pos_q;
                act_x   <= x_q;
                act_y   <= y_q;
                act_sc  <= sc_q;
            end else if (de_fall) begin
                ln_cnt <= ln_cnt + 1'b1;
            end
            // Source column advances once every scale pixels, restarting outside the window.
            if (de1 && inx) begin
                if (rx_q == act_sc) begin
                    rx_q <= '0;
                    sx_q <= sx_q + 1'b1;
                end else begin
                    rx_q <= rx_q + 1'b1;
                end
            end else begin
                rx_q <= '0;
                sx_q <= '0;
            end
            if (vs_rise || (de_fall && !iny)) begin
                ry_q <= '0;
                sy_q <= '0;
            end else if (de_fall) begin
                if (ry_q == act_sc) begin
                    ry_q <= '0;
                    sy_q <= sy_q + 1'b1;
                end else begin
                    ry_q <= ry_q + 1'b1;
                end
            end
        end
    end

    osd_bitmap_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_video (clk_video),
        .we        (wr_en),
        .wa        (wr_addr),
        .wd        (cmd.io_din[7:0]),
        .ra        (rd_addr),
        .rd        (rd_data)
    );

    assign pix_on = rd_data[bit2];

    always_ff @(posedge clk_video or posedge reset) begin
        if (reset) begin
            {din2, de2, hs2, vs2, win2, bit2} <= '0;
            {dout3, de3, hs3, vs3}            <= '0;
            {dout, de_out, hs_out, vs_out}    <= '0;
        end else begin
            {din2, de2, hs2, vs2, win2, bit2} <= {din1, de1, hs1, vs1, win1, sy_q[2:0]};
            dout3 <= win2 ? {osd_blend(din2[23:16], pix_on, OSD_COLOR[2], DSH),
                             osd_blend(din2[15:8],  pix_on, OSD_COLOR[1], DSH),
                             osd_blend(din2[7:0],   pix_on, OSD_COLOR[0], DSH)} : din2;
            {de3, hs3, vs3} <= {de2, hs2, vs2};
            {dout, de_out, hs_out, vs_out} <= {dout3, de3, hs3, vs3};
        end
    end

    assign osd_status = act_en;

endmodule

// File: tb/tb_osd_overlay_ms.sv
// Directed bench for osd_overlay_ms on a reduced 128x32 raster with a 64x16 bitmap.
module tb_osd_overlay_ms;

    localparam int OW = 64, OH = 16, DEPTH = OW * OH / 8;
    localparam int HA = 128, HT = 136, VA = 32, VT = 36;

    logic        clk_video = 1'b0;
    logic        reset     = 1'b1;
    logic [23:0] din = '0;
    logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
    logic [23:0] dout;
    logic        de_out, hs_out, vs_out, osd_status;

    always #5 clk_video = ~clk_video;

    osd_cmd_if cmd_if ();

    osd_overlay_ms #(.OSD_W(OW), .OSD_H(OH), .OSD_COLOR(3'd4), .DIM_SHIFT(1)) dut (
        .clk_video  (clk_video),
        .reset      (reset),
        .cmd        (cmd_if),
        .din        (din),
        .de_in      (de_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .dout       (dout),
        .de_out     (de_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .osd_status (osd_status)
    );

    int          vectors = 0, errors = 0;
    int          cyc = 0, t_de_in = 0, t_vs_in = 0, t_de_out = 0, t_vs_out = 0;
    int          oln = 0, opx = 0, npix = 0;
    logic        de_o_q = 1'b0, vs_o_q = 1'b0, got_de = 1'b0;
    logic [23:0] cap [VA][HA];
    logic [7:0]  bm [DEPTH];
    logic [15:0] cq [$];

    always @(posedge clk_video) cyc <= cyc + 1;

    // Output capture indexed by the DUT's own de_out/vs_out framing.
    always @(negedge clk_video) begin
        de_o_q <= de_out;
        vs_o_q <= vs_out;
        if (vs_out && !vs_o_q) begin
            oln <= 0; opx <= 0; npix <= 0; got_de <= 1'b0; t_vs_out <= cyc;
        end else if (de_out) begin
            if (oln < VA && opx < HA) cap[oln][opx] <= dout;
            opx  <= opx + 1;
            npix <= npix + 1;
            if (!got_de) begin got_de <= 1'b1; t_de_out <= cyc; end
        end else if (de_o_q) begin
            oln <= oln + 1; opx <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] dimmed(input logic [23:0] c);
        return {(c[23:16] >> 1) | 8'h40, c[15:8] >> 1, c[7:0] >> 1};
    endfunction

    task automatic send_cmd();
        @(negedge clk_video) cmd_if.io_osd = 1'b1;
        foreach (cq[i]) begin
            @(negedge clk_video) begin cmd_if.io_din = cq[i]; cmd_if.io_strobe = 1'b1; end
            @(negedge clk_video) cmd_if.io_strobe = 1'b0;
        end
        @(negedge clk_video) cmd_if.io_osd = 1'b0;
        @(negedge clk_video);
    endtask

    task automatic fill(input logic [7:0] v);
        cq = {16'h0020};
        for (int i = 0; i < DEPTH; i++) begin cq.push_back({8'h00, v}); bm[i] = v; end
        send_cmd();
    endtask

    task automatic run_frame(input bit ramp, input logic [23:0] base);
        for (int l = 0; l < VT; l++) begin
            for (int p = 0; p < HT; p++) begin
                @(negedge clk_video);
                vs_in = (l < 2);
                hs_in = (p >= 130 && p < 132);
                de_in = (l >= 2 && l < 2 + VA && p < HA);
                din   = de_in ? (ramp ? {8'(p), 8'(l - 2), 8'h80} : base) : 24'h0;
                if (l == 0 && p == 0) t_vs_in = cyc;
                if (l == 2 && p == 0) t_de_in = cyc;
            end
        end
    endtask

    task automatic check_frame(input string tag, input bit ramp, input logic [23:0] base,
                               input bit en, input int x0, input int y0, input int sc);
        logic [23:0] e;
        int sx, sy;
        check({tag, "_npix"}, npix, VA * HA);
        for (int l = 0; l < VA; l++) begin
            for (int p = 0; p < HA; p++) begin
                e = ramp ? {8'(p), 8'(l), 8'h80} : base;
                if (en && p >= x0 && p < x0 + OW * sc && l >= y0 && l < y0 + OH * sc) begin
                    sx = (p - x0) / sc;
                    sy = (l - y0) / sc;
                    e  = bm[(sy / 8) * OW + sx][sy % 8] ? 24'hFFFFFF : dimmed(base);
                end
                check($sformatf("%s_l%0d_p%0d", tag, l, p), cap[l][p], e);
            end
        end
    endtask

    initial begin
        int addr;
        cmd_if.io_osd = 1'b0; cmd_if.io_strobe = 1'b0; cmd_if.io_din = '0;
        repeat (3) @(negedge clk_video);
        check("rst_dout", dout, 0);
        check("rst_de", de_out, 0);
        check("rst_hs", hs_out, 0);
        check("rst_vs", vs_out, 0);
        check("rst_status", osd_status, 0);
        @(negedge clk_video) reset = 1'b0;

        run_frame(1, '0);
        run_frame(1, '0);
        check_frame("pass", 1, '0, 0, 0, 0, 1);
        check("lat_de", t_de_out - t_de_in, 4);
        check("lat_vs", t_vs_out - t_vs_in, 4);
        check("pass_status", osd_status, 0);

        fill(8'hFF);
        cq = {16'h0041}; send_cmd();
        check("status_before_vs", osd_status, 0);
        run_frame(0, 24'h808080);
        check_frame("centre_ff", 0, 24'h808080, 1, 32, 8, 1);
        check("status_on", osd_status, 1);
        check("centre_corner", cap[8][32], 24'hFFFFFF);
        check("centre_left_out", cap[8][31], 24'h808080);

        fill(8'h00);
        run_frame(0, 24'h404040);
        check_frame("tint", 0, 24'h404040, 1, 32, 8, 1);
        check("tint_px", cap[10][40], 24'h602020);

        cq = {16'h0020, 16'h0001}; send_cmd(); bm[0] = 8'h01;
        cq = {16'h0043, 16'd10, 16'd5, 16'd1}; send_cmd();
        run_frame(0, 24'h808080);
        check_frame("scale2", 0, 24'h808080, 1, 10, 5, 2);
        check("scale2_on", cap[6][11], 24'hFFFFFF);
        check("scale2_off", cap[7][12], 24'h404040);
        check("scale2_clip", cap[31][127], 24'h404040);

        fork
            run_frame(0, 24'h808080);
            begin
                repeat (HT * 12) @(negedge clk_video);
                cq = {16'h0040}; send_cmd();
            end
        join
        check_frame("midframe", 0, 24'h808080, 1, 10, 5, 2);
        check("mid_status", osd_status, 1);
        run_frame(0, 24'h808080);
        check_frame("disabled", 0, 24'h808080, 0, 0, 0, 1);
        check("off_status", osd_status, 0);

        fill(8'h00);
        cq = {16'h003F}; addr = 64;
        for (int i = 0; i < 108; i++) begin
            cq.push_back(i < 64 ? 16'h0000 : 16'h00FF);
            bm[addr] = (i < 64) ? 8'h00 : 8'hFF;
            addr = (addr + 1) % DEPTH;
        end
        send_cmd();
        cq = {16'h0043, 16'd0, 16'd0, 16'd0}; send_cmd();
        run_frame(0, 24'h808080);
        check_frame("wrap", 0, 24'h808080, 1, 0, 0, 1);
        check("wrap_first_px", cap[0][0], 24'hFFFFFF);
        check("wrap_43", cap[0][43], 24'hFFFFFF);
        check("wrap_44", cap[0][44], 24'h404040);

        fork
            run_frame(1, '0);
            begin
                repeat (HT * 18 + 5) @(negedge clk_video);
                reset = 1'b1;
                #1;
                check("midrst_dout", dout, 0);
                check("midrst_de", de_out, 0);
                check("midrst_status", osd_status, 0);
                repeat (3) @(negedge clk_video);
                reset = 1'b0;
            end
        join
        cq = {16'h0041}; send_cmd();
        run_frame(1, '0);
        check_frame("post_rst", 1, '0, 0, 0, 0, 1);
        check("post_rst_status", osd_status, 1);
        run_frame(0, 24'h808080);
        check_frame("post_meas", 0, 24'h808080, 1, 32, 8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
